register_file: RTL and testbench
================================

// Module: register_file
// PURPOSE
//   32-entry x 32-bit general-purpose register file for the board-level datapath lab.
//   - One synchronous write port and one combinational read port share a single address.
//   - Write data, address and write-enable arrive packed on the SW bus.
//   - The addressed entry is driven continuously onto LEDR for display.
// PARAMETERS
//   DATA_W  32   width of each register and of the LEDR / SW data field
//   ADDR_W  5    address width; depth = 2**ADDR_W (32 entries)
// PORTS
//   clk   in   1                    single clock; all state updates on rising edge
//   rst   in   1                    synchronous, active-high reset
//   SW    in   DATA_W+ADDR_W+1(38)  packed control/data bus, fields below
//   LEDR  out  DATA_W(32)           read data of the entry selected by SW address field
// BEHAVIOUR
//   Clocking and reset (already decided):
//   - One clock (clk); reset rst is synchronous and active-high.
//   SW field map (default widths):
//   - SW[37]    = we   (write enable)
//   - SW[36:32] = addr
//   - SW[31:0]  = wdata
//   - General form: we = SW[DATA_W+ADDR_W], addr = SW[DATA_W+ADDR_W-1:DATA_W],
//     wdata = SW[DATA_W-1:0].
//   Storage:
//   - mem[0..2**ADDR_W-1], DATA_W bits each.
//   - All entries, including entry 0, are ordinary writable registers; no hardwired zero.
//   Reset:
//   - On a rising clk edge with rst=1, every entry is cleared to 0.
//   - rst has priority over we; no write occurs in that cycle.
//   - LEDR reads 0 for every address after reset.
//   Write:
//   - On a rising clk edge with rst=0 and we=1, mem[addr] <= wdata.
//   - Exactly one entry is updated per write; all other entries hold.
//   - we=0: no entry changes.
//   Read:
//   - Combinational, zero latency: LEDR = mem[addr] at all times.
//   - Address changes are reflected immediately, with no clock needed.
//   - Read-during-write to the same address: LEDR shows the old value until the edge,
//     then the new value. There is no write-through bypass.
//   Boundaries:
//   - addr is always in range (full 2**ADDR_W decode); 0 and 31 behave like any entry.
//   - Repeated writes to the same entry: last written value wins.
//   - Before the first reset, contents are undefined (X in simulation). Benches reset first.
//   - Reset asserted mid-sequence discards all previously written data at the next edge.
// TESTING
//   1. rst=1 for 1 edge, then sweep addr 0..31 with we=0 -> LEDR=32'h0 for every address.
//   2. we=1, wdata=FFFF_FFFF, addr stepping 0..6 one per edge;
//      then we=0, sweep addr 0..6 -> LEDR=FFFF_FFFF; addr 7 -> LEDR=0.
//   3. Write 0x1234_5678 to addr 31 and 0xA5A5_A5A5 to addr 1.
//      Read 31, 1, 30 -> 1234_5678, A5A5_A5A5, 0000_0000.
//   4. Hold we=1, addr=5, wdata=0xDEAD_BEEF over an edge after 5 held 0xFFFF_FFFF.
//      LEDR=FFFF_FFFF before the edge, DEAD_BEEF after it.
//   5. we=0 with wdata changing for several edges -> no entry changes
//      (re-read addr 0..6 unchanged).
//   6. rst=1 and we=1 (addr=2, wdata=0x5555_5555) on the same edge -> all entries 0;
//      LEDR at addr 2 = 0.

Source files
------------

// File: rtl/register_file.sv
// 32 x 32 register file: one synchronous write port and one
// combinational read port sharing the address field of SW.
module register_file #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_W+ADDR_W:0]   SW,
  output logic [DATA_W-1:0]        LEDR
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;

  logic [DATA_W-1:0] mem [DEPTH];

  assign we    = SW[DATA_W+ADDR_W];
  assign addr  = SW[DATA_W+ADDR_W-1:DATA_W];
  assign wdata = SW[DATA_W-1:0];

  // rst wins over we: a write in the reset cycle is dropped
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[addr] <= wdata;
    end
  end

  // no bypass: same-address write is visible only after the edge
  assign LEDR = mem[addr];

endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench for register_file: expected read data is queued
// when an address is driven and compared once LEDR settles.
module tb_register_file;

  logic        clk;
  logic        rst;
  logic [37:0] SW;
  logic [31:0] LEDR;

  logic [31:0] model [32];
  logic [31:0] q [$];
  logic [31:0] exp_v;
  int          total;
  int          bad;

  register_file dut (
    .clk  (clk),
    .rst  (rst),
    .SW   (SW),
    .LEDR (LEDR)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: sim time limit reached, got=timeout want=finish");
    $fatal(1);
  end

  task automatic drive_read(input int a);
    SW = {1'b0, a[4:0], 32'h0};
    q.push_back(model[a]);
  endtask

  task automatic do_write(input int a, input logic [31:0] d);
    @(negedge clk);
    SW = {1'b1, a[4:0], d};
    @(posedge clk);
    model[a] = d;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    SW  = '0;
    @(posedge clk);
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    @(negedge clk);
    rst = 1'b0;
    for (int a = 0; a < 32; a++) begin
      drive_read(a);
      #1;
      exp_v = q.pop_front();
      total++;
      if (LEDR !== exp_v || LEDR !== 32'h0) begin
        bad++;
        $display("FAIL reset_read a=%0d got=%h want=%h", a, LEDR, 32'h0);
      end
    end
  endtask

  task automatic test_fill();
    for (int a = 0; a < 7; a++) do_write(a, 32'hFFFF_FFFF);
    @(negedge clk);
    for (int a = 0; a < 8; a++) begin
      drive_read(a);
      #1;
      exp_v = q.pop_front();
      total++;
      if (LEDR !== exp_v) begin
        bad++;
        $display("FAIL fill_read a=%0d got=%h want=%h", a, LEDR, exp_v);
      end
    end
  endtask

  task automatic test_extremes();
    int addrs [3];
    addrs = '{31, 1, 30};
    do_write(31, 32'h1234_5678);
    do_write(1, 32'hA5A5_A5A5);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      drive_read(addrs[k]);
      #1;
      exp_v = q.pop_front();
      total++;
      if (LEDR !== exp_v) begin
        bad++;
        $display("FAIL extreme_read a=%0d got=%h want=%h",
                 addrs[k], LEDR, exp_v);
      end
    end
  endtask

  task automatic test_rdw();
    @(negedge clk);
    SW = {1'b1, 5'd5, 32'hDEAD_BEEF};
    q.push_back(model[5]);
    #1;
    exp_v = q.pop_front();
    total++;
    if (LEDR !== exp_v || exp_v !== 32'hFFFF_FFFF) begin
      bad++;
      $display("FAIL rdw_before got=%h want=%h", LEDR, 32'hFFFF_FFFF);
    end
    @(posedge clk);
    model[5] = 32'hDEAD_BEEF;
    q.push_back(model[5]);
    #1;
    exp_v = q.pop_front();
    total++;
    if (LEDR !== exp_v) begin
      bad++;
      $display("FAIL rdw_after got=%h want=%h", LEDR, exp_v);
    end
    @(negedge clk);
    SW = {1'b0, 5'd5, 32'h0};
  endtask

  task automatic test_we_low();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      SW = {1'b0, k[4:0], $urandom()};
      @(posedge clk);
    end
    @(negedge clk);
    for (int a = 0; a < 7; a++) begin
      drive_read(a);
      #1;
      exp_v = q.pop_front();
      total++;
      if (LEDR !== exp_v) begin
        bad++;
        $display("FAIL we_low_read a=%0d got=%h want=%h", a, LEDR, exp_v);
      end
    end
  endtask

  task automatic test_back_to_back();
    do_write(9, 32'h1111_1111);
    do_write(9, 32'h2222_2222);
    do_write(9, 32'h3333_3333);
    @(negedge clk);
    drive_read(9);
    #1;
    exp_v = q.pop_front();
    total++;
    if (LEDR !== exp_v || exp_v !== 32'h3333_3333) begin
      bad++;
      $display("FAIL last_wins got=%h want=%h", LEDR, 32'h3333_3333);
    end
  endtask

  task automatic test_rst_priority();
    @(negedge clk);
    rst = 1'b1;
    SW  = {1'b1, 5'd2, 32'h5555_5555};
    @(posedge clk);
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    @(negedge clk);
    rst = 1'b0;
    for (int a = 0; a < 32; a++) begin
      drive_read(a);
      #1;
      exp_v = q.pop_front();
      total++;
      if (LEDR !== exp_v) begin
        bad++;
        $display("FAIL rst_prio_read a=%0d got=%h want=%h", a, LEDR, exp_v);
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    SW    = '0;
    test_reset();
    test_fill();
    test_extremes();
    test_rdw();
    test_we_low();
    test_back_to_back();
    test_rst_priority();
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL queue_drain got=%0d want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
